// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared enums for rggen bit fields, including counter arithmetic mode.
package rggen_rtl_pkg;
  typedef enum logic {
    RGGEN_SW_ACCESS,
    RGGEN_HW_ACCESS
  } rggen_sw_hw_access;
  typedef enum logic {
    RGGEN_COUNTER_WRAP,
    RGGEN_COUNTER_SATURATE
  } rggen_counter_mode;
endpackage

// File: rtl/rggen_bit_field_if.sv
// rggen_bit_field_if: SW access bundle between a register and one of its bit fields.
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;
  modport register (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );
  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_counter_delta.sv
// rggen_counter_delta: signed net count of enabled up lanes minus enabled down lanes.
module rggen_counter_delta #(
  parameter int EVENTS = 1,
  localparam int DW = $clog2(EVENTS + 1) + 1
)(
  input  logic                 i_count_enable,
  input  logic [EVENTS-1:0]    i_up,
  input  logic [EVENTS-1:0]    i_down,
  output logic signed [DW-1:0] o_delta
);
  always_comb begin
    o_delta = '0;
    for (int i = 0; i < EVENTS; i++)
      o_delta = o_delta + DW'(i_up[i] & i_count_enable) - DW'(i_down[i] & i_count_enable);
  end
endmodule

// File: rtl/rggen_bit_field_counter.sv
// rggen_bit_field_counter: SW-accessible event counter with wrap/saturate and sticky flags.
// Define RGGEN_COUNTER_THRESHOLD_EN to build the threshold comparator and o_threshold_hit register.
module rggen_bit_field_counter
  import rggen_rtl_pkg::*;
#(
  parameter int                WIDTH             = 16,
  parameter logic [WIDTH-1:0]  INITIAL_VALUE     = '0,
  parameter int                EVENTS            = 1,
  parameter rggen_counter_mode MODE              = RGGEN_COUNTER_WRAP,
  parameter rggen_sw_hw_access PRECEDENCE_ACCESS = RGGEN_SW_ACCESS,
  parameter bit                SW_READ_CLEAR     = 1'b0
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rggen_bit_field_if.bit_field  bit_field_if,
  input  logic                  i_count_enable,
  input  logic [EVENTS-1:0]     i_up,
  input  logic [EVENTS-1:0]     i_down,
  input  logic                  i_hw_clear,
  input  logic [WIDTH-1:0]      i_threshold,
  output logic [WIDTH-1:0]      o_value,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_threshold_hit
);
  localparam int DW = $clog2(EVENTS + 1) + 1;
  // Sum is widened past WIDTH+2 when a narrow counter meets a large negative delta.
  localparam int SW = (WIDTH > DW ? WIDTH : DW) + 2;
  logic signed [DW-1:0] delta;
  logic [WIDTH-1:0] value_q, value_d, base, wr_value;
  logic [SW-1:0] sum;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic rd, wr, rc, use_delta, ovf, unf;
  rggen_counter_delta #(.EVENTS(EVENTS)) u_delta (
    .i_count_enable (i_count_enable),
    .i_up           (i_up),
    .i_down         (i_down),
    .o_delta        (delta)
  );
  always_comb begin
    rd = bit_field_if.valid && (|bit_field_if.read_mask);
    wr = bit_field_if.valid && (|bit_field_if.write_mask);
    rc = SW_READ_CLEAR && rd;
    wr_value = (value_q & ~bit_field_if.write_mask) | (bit_field_if.write_data & bit_field_if.write_mask);
    base = rc ? '0 : wr ? wr_value : value_q;
    use_delta = rc || !wr || (PRECEDENCE_ACCESS == RGGEN_HW_ACCESS);
    sum = {{(SW-WIDTH){1'b0}}, base} + (use_delta ? {{(SW-DW){delta[DW-1]}}, delta} : '0);
    unf = sum[SW-1];
    ovf = !sum[SW-1] && (|sum[SW-2:WIDTH]);
    value_d = i_hw_clear ? INITIAL_VALUE :
              (MODE == RGGEN_COUNTER_SATURATE && ovf) ? '1 :
              (MODE == RGGEN_COUNTER_SATURATE && unf) ? '0 : sum[WIDTH-1:0];
    overflow_d = !i_hw_clear && (ovf || (overflow_q && !(rc || wr)));
    underflow_d = !i_hw_clear && (unf || (underflow_q && !(rc || wr)));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= INITIAL_VALUE;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      value_q <= value_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign bit_field_if.read_data = value_q & bit_field_if.read_mask;
  assign bit_field_if.value = value_q;
  assign o_value = value_q;
  assign o_overflow = overflow_q;
  assign o_underflow = underflow_q;
`ifdef RGGEN_COUNTER_THRESHOLD_EN
  logic hit_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hit_q <= 1'b0;
    else hit_q <= value_d >= i_threshold;
  end
  assign o_threshold_hit = hit_q;
`else
  logic unused_threshold;
  assign unused_threshold = ^i_threshold;
  assign o_threshold_hit = 1'b0;
`endif
endmodule

// File: tb/tb_rggen_bit_field_counter.sv
// tb_rggen_bit_field_counter: four counter configurations driven by shared stimulus and
// checked against an integer reference model; directed cases plus randomized traffic.
module tb_rggen_bit_field_counter;
  import rggen_rtl_pkg::*;
  localparam logic [3:0]  SAT  = 4'b1010;
  localparam logic [3:0]  HWP  = 4'b0110;
  localparam logic [3:0]  RC   = 4'b1100;
  localparam logic [31:0] INIT = 32'h5A_00_33_00;
`ifdef RGGEN_COUNTER_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic valid = 1'b0, en = 1'b0, clr = 1'b0;
  logic [7:0] rmask = '0, wmask = '0, wdata = '0, thr = '0;
  logic [3:0] up = '0, down = '0;
  logic [31:0] valv, rdv;
  logic [3:0] ovv, unv, thv;
  int errors = 0, checks = 0;
  int mv[4];
  bit mo[4], mu[4], mh[4];
  for (genvar g = 0; g < 4; g++) begin : gd
    rggen_bit_field_if #(.WIDTH(8)) bf ();
    assign bf.valid = valid;
    assign bf.read_mask = rmask;
    assign bf.write_mask = wmask;
    assign bf.write_data = wdata;
    assign rdv[g*8+:8] = bf.read_data;
    rggen_bit_field_counter #(
      .WIDTH(8), .INITIAL_VALUE(INIT[g*8+:8]), .EVENTS(4),
      .MODE(SAT[g] ? RGGEN_COUNTER_SATURATE : RGGEN_COUNTER_WRAP),
      .PRECEDENCE_ACCESS(HWP[g] ? RGGEN_HW_ACCESS : RGGEN_SW_ACCESS),
      .SW_READ_CLEAR(RC[g])
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(bf.bit_field),
      .i_count_enable(en), .i_up(up), .i_down(down), .i_hw_clear(clr),
      .i_threshold(thr), .o_value(valv[g*8+:8]), .o_overflow(ovv[g]),
      .o_underflow(unv[g]), .o_threshold_hit(thv[g])
    );
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic mreset();
    for (int g = 0; g < 4; g++) begin
      mv[g] = int'(INIT[g*8+:8]);
      mo[g] = 0; mu[g] = 0; mh[g] = 0;
    end
  endtask
  task automatic mstep();
    int d, s, base;
    bit rdq, wrq, rcq, apply;
    d = en ? $countones(up) - $countones(down) : 0;
    rdq = valid && rmask != 0;
    wrq = valid && wmask != 0;
    for (int g = 0; g < 4; g++) begin
      if (clr) begin
        mv[g] = int'(INIT[g*8+:8]);
        mo[g] = 0; mu[g] = 0;
      end else begin
        rcq = RC[g] && rdq;
        if (rcq || wrq) begin mo[g] = 0; mu[g] = 0; end
        base = rcq ? 0 : wrq ? ((mv[g] & ~int'(wmask)) | int'(wdata & wmask)) : mv[g];
        apply = rcq || !wrq || HWP[g];
        s = base + (apply ? d : 0);
        if (s > 255) mo[g] = 1;
        if (s < 0) mu[g] = 1;
        mv[g] = SAT[g] ? (s > 255 ? 255 : s < 0 ? 0 : s) : (s & 255);
      end
      mh[g] = THR_EN && (mv[g] >= int'(thr));
    end
  endtask
  task automatic chk_out(input string tag);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s value%0d", tag, g), 64'(valv[g*8+:8]), 64'(mv[g]));
      check($sformatf("%s ovf%0d", tag, g), 64'(ovv[g]), 64'(mo[g]));
      check($sformatf("%s unf%0d", tag, g), 64'(unv[g]), 64'(mu[g]));
      check($sformatf("%s thr%0d", tag, g), 64'(thv[g]), 64'(mh[g]));
    end
  endtask
  task automatic cycle(input string tag);
    #1;
    for (int g = 0; g < 4; g++)
      check($sformatf("%s rdata%0d", tag, g), 64'(rdv[g*8+:8]), 64'(mv[g] & int'(rmask)));
    mstep();
    @(posedge clk);
    #1;
    chk_out(tag);
    valid = 0; rmask = '0; wmask = '0; up = '0; down = '0; clr = 0; en = 1;
  endtask
  task automatic setv(input logic [7:0] v);
    valid = 1; wmask = 8'hFF; wdata = v;
    cycle("set");
  endtask
  initial begin
    mreset();
    #12;
    chk_out("reset");
    rst_n = 1;
    cycle("idle");
    setv(8'hFE);
    up = 4'b0111;
    cycle("wrap_ovf");
    check("tp wrap value", 64'(valv[7:0]), 64'h01);
    check("tp wrap ovf", 64'(ovv[0]), 64'h1);
    setv(8'h02);
    down = 4'b1111;
    cycle("sat_unf");
    check("tp sat value", 64'(valv[15:8]), 64'h00);
    check("tp sat unf", 64'(unv[1]), 64'h1);
    down = 4'b0001;
    cycle("sat_hold");
    check("tp sat hold", 64'(valv[15:8]), 64'h00);
    setv(8'h10);
    valid = 1; wmask = 8'hFF; wdata = 8'h55; up = 4'b0001;
    cycle("prec");
    check("tp sw prec", 64'(valv[7:0]), 64'h55);
    check("tp hw prec", 64'(valv[15:8]), 64'h56);
    setv(8'h20);
    valid = 1; rmask = 8'hFF; up = 4'b0011;
    #1;
    check("tp rc rdata", 64'(rdv[23:16]), 64'h20);
    cycle("rclr");
    check("tp rc value", 64'(valv[23:16]), 64'h02);
    up = 4'b1111;
    cycle("pre_clr");
    clr = 1; valid = 1; wmask = 8'hFF; wdata = 8'hAA; up = 4'b0011;
    cycle("hwclr");
    check("tp hwclr value", 64'(valv[15:8]), 64'h33);
    up = 4'b0011;
    #3;
    rst_n = 0;
    #1;
    mreset();
    chk_out("async_rst");
    @(posedge clk);
    #1;
    chk_out("rst_hold");
    rst_n = 1;
    up = '0;
    setv(8'h04);
    thr = 8'h05; up = 4'b0001;
    cycle("thresh");
    check("tp thresh value", 64'(valv[7:0]), 64'h05);
    check("tp thresh hit", 64'(thv[0]), 64'(THR_EN));
    for (int n = 0; n < 400; n++) begin
      valid = ($urandom % 3) == 0;
      rmask = ($urandom % 2) ? 8'hFF : 8'($urandom);
      wmask = ($urandom % 3) == 0 ? 8'h00 : ($urandom % 2) ? 8'hFF : 8'($urandom);
      wdata = 8'($urandom);
      en = ($urandom % 4) != 0;
      up = 4'($urandom);
      down = 4'($urandom);
      clr = ($urandom % 25) == 0;
      thr = 8'($urandom);
      cycle("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
